// File: rtl/calc2_top.sv
// Four-port two-operand calculator: per-port command and response queues shared
// by a round-robin add/sub unit and a round-robin shift unit running in parallel.
module calc2_top (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [1:0]  req1_tag_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [1:0]  req2_tag_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [1:0]  req3_tag_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  input  logic [1:0]  req4_tag_in,
  output logic [31:0] out_data1,
  output logic [1:0]  out_resp1,
  output logic [1:0]  out_tag1,
  output logic [31:0] out_data2,
  output logic [1:0]  out_resp2,
  output logic [1:0]  out_tag2,
  output logic [31:0] out_data3,
  output logic [1:0]  out_resp3,
  output logic [1:0]  out_tag3,
  output logic [31:0] out_data4,
  output logic [1:0]  out_resp4,
  output logic [1:0]  out_tag4,
  input  logic        a_clk,
  input  logic        b_clk,
  input  logic        scan_in,
  output logic        scan_out
);

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [1:0]  tag;
    logic [31:0] data;
  } rsp_t;

  logic [3:0]  w_cmd_in  [4];
  logic [31:0] w_data_in [4];
  logic [1:0]  w_tag_in  [4];

  assign w_cmd_in[0] = req1_cmd_in;  assign w_data_in[0] = req1_data_in;  assign w_tag_in[0] = req1_tag_in;
  assign w_cmd_in[1] = req2_cmd_in;  assign w_data_in[1] = req2_data_in;  assign w_tag_in[1] = req2_tag_in;
  assign w_cmd_in[2] = req3_cmd_in;  assign w_data_in[2] = req3_data_in;  assign w_tag_in[2] = req3_tag_in;
  assign w_cmd_in[3] = req4_cmd_in;  assign w_data_in[3] = req4_data_in;  assign w_tag_in[3] = req4_tag_in;

  logic w_unused;
  assign w_unused = a_clk ^ b_clk ^ scan_in;
  assign scan_out = 1'b0;

  function automatic logic f_is_shift(input logic [3:0] cmd);
    return (cmd == 4'd5) || (cmd == 4'd6);
  endfunction

  // Invalid commands fall through to the add/sub unit and report an error.
  function automatic rsp_t f_addsub(input cmd_t e);
    rsp_t        r;
    logic [32:0] s;
    r.tag  = e.tag;
    r.resp = 2'd2;
    r.data = 32'd0;
    s      = {1'b0, e.op1} + {1'b0, e.op2};
    case (e.cmd)
      4'd1: if (!s[32]) begin r.resp = 2'd1; r.data = s[31:0]; end
      4'd2: if (e.op2 <= e.op1) begin r.resp = 2'd1; r.data = e.op1 - e.op2; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic rsp_t f_shift(input cmd_t e);
    rsp_t r;
    r.tag  = e.tag;
    r.resp = 2'd1;
    r.data = (e.cmd == 4'd5) ? (e.op1 << e.op2[4:0]) : (e.op1 >> e.op2[4:0]);
    return r;
  endfunction

  logic        r_pend [4];
  logic [3:0]  r_pcmd [4];
  logic [1:0]  r_ptag [4];
  logic [31:0] r_pop1 [4];
  cmd_t        r_cq   [4][4];
  logic [2:0]  r_ccnt [4];
  rsp_t        r_rq   [4][4];
  logic [2:0]  r_rcnt [4];
  logic [1:0]  r_rr_as;
  logic [1:0]  r_rr_sh;

  logic        w_as_avail [4];
  logic [1:0]  w_as_idx   [4];
  logic        w_sh_avail [4];
  logic [1:0]  w_sh_idx   [4];
  logic        w_as_gnt;
  logic [1:0]  w_as_port;
  logic        w_sh_gnt;
  logic [1:0]  w_sh_port;
  rsp_t        w_as_rsp;
  rsp_t        w_sh_rsp;
  cmd_t        w_cq_nxt   [4][4];
  logic [2:0]  w_ccnt_nxt [4];
  rsp_t        w_rq_nxt   [4][4];
  logic [2:0]  w_rcnt_nxt [4];
  rsp_t        w_out      [4];

  // Oldest queued entry per unit; entries are kept compacted, index 0 oldest.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      w_as_avail[p] = 1'b0;
      w_as_idx[p]   = 2'd0;
      w_sh_avail[p] = 1'b0;
      w_sh_idx[p]   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
        if (3'(i) < r_ccnt[p]) begin
          if (f_is_shift(r_cq[p][i].cmd)) begin
            w_sh_avail[p] = 1'b1;
            w_sh_idx[p]   = 2'(i);
          end else begin
            w_as_avail[p] = 1'b1;
            w_as_idx[p]   = 2'(i);
          end
        end
      end
    end
  end

  always_comb begin : arb
    logic [1:0] v_p;
    w_as_gnt  = 1'b0;
    w_as_port = r_rr_as;
    w_sh_gnt  = 1'b0;
    w_sh_port = r_rr_sh;
    for (int k = 3; k >= 0; k--) begin
      v_p = r_rr_as + 2'(k);
      if (w_as_avail[v_p]) begin w_as_gnt = 1'b1; w_as_port = v_p; end
      v_p = r_rr_sh + 2'(k);
      if (w_sh_avail[v_p]) begin w_sh_gnt = 1'b1; w_sh_port = v_p; end
    end
    w_as_rsp = f_addsub(r_cq[w_as_port][w_as_idx[w_as_port]]);
    w_sh_rsp = f_shift(r_cq[w_sh_port][w_sh_idx[w_sh_port]]);
  end

  always_comb begin : cq_next
    logic [2:0] v_n;
    logic       v_take;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) w_cq_nxt[p][i] = r_cq[p][i];
      v_n = 3'd0;
      for (int i = 0; i < 4; i++) begin
        v_take = (w_as_gnt && w_as_port == 2'(p) && w_as_idx[p] == 2'(i)) ||
                 (w_sh_gnt && w_sh_port == 2'(p) && w_sh_idx[p] == 2'(i));
        if (3'(i) < r_ccnt[p] && !v_take) begin
          w_cq_nxt[p][v_n[1:0]] = r_cq[p][i];
          v_n = v_n + 3'd1;
        end
      end
      if (r_pend[p]) begin
        w_cq_nxt[p][v_n[1:0]] = '{cmd: r_pcmd[p], tag: r_ptag[p], op1: r_pop1[p], op2: w_data_in[p]};
        v_n = v_n + 3'd1;
      end
      w_ccnt_nxt[p] = v_n;
    end
  end

  // Head is presented (and popped) every cycle it exists; add/sub result lands before shift.
  always_comb begin : rq_next
    logic [2:0] v_n;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) w_rq_nxt[p][i] = r_rq[p][i];
      v_n = r_rcnt[p];
      if (r_rcnt[p] != 3'd0) begin
        for (int i = 0; i < 3; i++) w_rq_nxt[p][i] = r_rq[p][i+1];
        v_n = v_n - 3'd1;
      end
      if (w_as_gnt && w_as_port == 2'(p)) begin
        w_rq_nxt[p][v_n[1:0]] = w_as_rsp;
        v_n = v_n + 3'd1;
      end
      if (w_sh_gnt && w_sh_port == 2'(p)) begin
        w_rq_nxt[p][v_n[1:0]] = w_sh_rsp;
        v_n = v_n + 3'd1;
      end
      w_rcnt_nxt[p] = v_n;
      w_out[p]      = (r_rcnt[p] != 3'd0) ? r_rq[p][0] : '0;
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_rr_as <= 2'd0;
      r_rr_sh <= 2'd0;
      for (int p = 0; p < 4; p++) begin
        r_pend[p] <= 1'b0;
        r_pcmd[p] <= 4'd0;
        r_ptag[p] <= 2'd0;
        r_pop1[p] <= 32'd0;
        r_ccnt[p] <= 3'd0;
        r_rcnt[p] <= 3'd0;
        for (int i = 0; i < 4; i++) begin
          r_cq[p][i] <= '0;
          r_rq[p][i] <= '0;
        end
      end
    end else begin
      if (w_as_gnt) r_rr_as <= w_as_port + 2'd1;
      if (w_sh_gnt) r_rr_sh <= w_sh_port + 2'd1;
      for (int p = 0; p < 4; p++) begin
        if (r_pend[p]) begin
          r_pend[p] <= 1'b0;
        end else if (w_cmd_in[p] != 4'd0) begin
          r_pend[p] <= 1'b1;
          r_pcmd[p] <= w_cmd_in[p];
          r_ptag[p] <= w_tag_in[p];
          r_pop1[p] <= w_data_in[p];
        end
        r_ccnt[p] <= w_ccnt_nxt[p];
        r_rcnt[p] <= w_rcnt_nxt[p];
        for (int i = 0; i < 4; i++) begin
          r_cq[p][i] <= w_cq_nxt[p][i];
          r_rq[p][i] <= w_rq_nxt[p][i];
        end
      end
    end
  end

  assign {out_resp1, out_tag1, out_data1} = w_out[0];
  assign {out_resp2, out_tag2, out_data2} = w_out[1];
  assign {out_resp3, out_tag3, out_data3} = w_out[2];
  assign {out_resp4, out_tag4, out_data4} = w_out[3];

endmodule

// File: tb/tb_calc2_top.sv
// Directed bench for calc2_top: single-port operations, boundaries, four-port
// contention with an out-of-order shift return, and reset while a command is in flight.
module tb_calc2_top;

  logic        c_clk;
  logic        reset;
  logic [3:0]  t_cmd  [4];
  logic [31:0] t_data [4];
  logic [1:0]  t_tag  [4];
  logic [31:0] out_data1, out_data2, out_data3, out_data4;
  logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [1:0]  out_tag1, out_tag2, out_tag3, out_tag4;
  logic        scan_out;

  int n_checks = 0;
  int n_errors = 0;

  calc2_top dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(t_cmd[0]), .req1_data_in(t_data[0]), .req1_tag_in(t_tag[0]),
    .req2_cmd_in(t_cmd[1]), .req2_data_in(t_data[1]), .req2_tag_in(t_tag[1]),
    .req3_cmd_in(t_cmd[2]), .req3_data_in(t_data[2]), .req3_tag_in(t_tag[2]),
    .req4_cmd_in(t_cmd[3]), .req4_data_in(t_data[3]), .req4_tag_in(t_tag[3]),
    .out_data1(out_data1), .out_resp1(out_resp1), .out_tag1(out_tag1),
    .out_data2(out_data2), .out_resp2(out_resp2), .out_tag2(out_tag2),
    .out_data3(out_data3), .out_resp3(out_resp3), .out_tag3(out_tag3),
    .out_data4(out_data4), .out_resp4(out_resp4), .out_tag4(out_tag4),
    .a_clk(1'b0), .b_clk(1'b0), .scan_in(1'b0), .scan_out(scan_out)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [35:0] outp(input int p);
    case (p)
      0:       return {out_resp1, out_tag1, out_data1};
      1:       return {out_resp2, out_tag2, out_data2};
      2:       return {out_resp3, out_tag3, out_data3};
      default: return {out_resp4, out_tag4, out_data4};
    endcase
  endfunction

  // Response words are {resp, tag, data}; checked mid-cycle on the falling edge.
  task automatic expect_all(input string nm, input logic [35:0] e0, input logic [35:0] e1,
                            input logic [35:0] e2, input logic [35:0] e3);
    @(negedge c_clk);
    chk($sformatf("%s_p1", nm), 64'(outp(0)), 64'(e0));
    chk($sformatf("%s_p2", nm), 64'(outp(1)), 64'(e1));
    chk($sformatf("%s_p3", nm), 64'(outp(2)), 64'(e2));
    chk($sformatf("%s_p4", nm), 64'(outp(3)), 64'(e3));
  endtask

  task automatic cyc();
    @(posedge c_clk);
    #1;
  endtask

  task automatic clr_in();
    for (int p = 0; p < 4; p++) begin
      t_cmd[p] = 4'd0; t_data[p] = 32'd0; t_tag[p] = 2'd0;
    end
  endtask

  task automatic do_reset();
    cyc(); reset = 1'b1; clr_in();
    cyc();
    cyc(); reset = 1'b0;
  endtask

  // One command on port p; junk cmd in the operand-2 cycle must be ignored.
  task automatic run1(input string nm, input int p, input logic [3:0] c, input logic [1:0] tg,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] er, input logic [31:0] ed);
    logic [35:0] e [4];
    cyc(); t_cmd[p] = c; t_tag[p] = tg; t_data[p] = a;
    cyc(); t_cmd[p] = 4'hF; t_tag[p] = ~tg; t_data[p] = b;
    cyc(); clr_in();
    expect_all({nm, "_t2"}, 36'd0, 36'd0, 36'd0, 36'd0);
    for (int i = 0; i < 4; i++) e[i] = 36'd0;
    e[p] = {er, tg, ed};
    cyc();
    expect_all({nm, "_t3"}, e[0], e[1], e[2], e[3]);
    cyc();
    expect_all({nm, "_t4"}, 36'd0, 36'd0, 36'd0, 36'd0);
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    expect_all("rst", 36'd0, 36'd0, 36'd0, 36'd0);
    @(negedge c_clk);
    chk("scan_out", 64'(scan_out), 64'd0);
    cyc(); reset = 1'b0;

    run1("add57",    0, 4'd1, 2'd2, 32'h5,        32'h7,  2'd1, 32'hC);
    run1("addovf",   1, 4'd1, 2'd1, 32'hFFFFFFFF, 32'h1,  2'd2, 32'h0);
    run1("addmax",   1, 4'd1, 2'd3, 32'hFFFFFFFE, 32'h1,  2'd1, 32'hFFFFFFFF);
    run1("subund",   2, 4'd2, 2'd3, 32'h3,        32'h5,  2'd2, 32'h0);
    run1("sub53",    2, 4'd2, 2'd0, 32'h5,        32'h3,  2'd1, 32'h2);
    run1("subeq",    2, 4'd2, 2'd1, 32'h7,        32'h7,  2'd1, 32'h0);
    run1("shl",      3, 4'd5, 2'd1, 32'h1,        32'h24, 2'd1, 32'h10);
    run1("shr",      3, 4'd6, 2'd2, 32'h80000000, 32'd31, 2'd1, 32'h1);
    run1("shlout",   3, 4'd5, 2'd0, 32'hF0000000, 32'd4,  2'd1, 32'h0);
    run1("inval",    0, 4'd3, 2'd1, 32'h1234,     32'h1,  2'd2, 32'h0);

    // All four ports add at once, released in the reset-deassert cycle; port 4 also shifts.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      t_cmd[p] = 4'd1; t_tag[p] = 2'd0; t_data[p] = 32'(10 * (p + 1));
    end
    cyc();
    for (int p = 0; p < 4; p++) begin
      t_cmd[p] = 4'd0; t_data[p] = 32'(p + 1);
    end
    cyc(); clr_in(); t_cmd[3] = 4'd5; t_tag[3] = 2'd1; t_data[3] = 32'd3;
    expect_all("all_t2", 36'd0, 36'd0, 36'd0, 36'd0);
    cyc(); clr_in(); t_data[3] = 32'd2;
    expect_all("all_t3", {2'd1, 2'd0, 32'd11}, 36'd0, 36'd0, 36'd0);
    cyc(); clr_in();
    expect_all("all_t4", 36'd0, {2'd1, 2'd0, 32'd22}, 36'd0, 36'd0);
    cyc();
    expect_all("all_t5", 36'd0, 36'd0, {2'd1, 2'd0, 32'd33}, {2'd1, 2'd1, 32'd12});
    cyc();
    expect_all("all_t6", 36'd0, 36'd0, 36'd0, {2'd1, 2'd0, 32'd44});
    cyc();
    expect_all("all_t7", 36'd0, 36'd0, 36'd0, 36'd0);

    // Reset pulse during the shift's operand-2 cycle discards everything in flight.
    do_reset();
    t_cmd[0] = 4'd1; t_tag[0] = 2'd0; t_data[0] = 32'd1;
    cyc(); t_cmd[0] = 4'd0; t_data[0] = 32'd2;
    cyc(); t_cmd[0] = 4'd5; t_tag[0] = 2'd1; t_data[0] = 32'd1;
    expect_all("rp_t2", 36'd0, 36'd0, 36'd0, 36'd0);
    cyc(); t_cmd[0] = 4'd0; t_data[0] = 32'd3; reset = 1'b1;
    expect_all("rp_in", 36'd0, 36'd0, 36'd0, 36'd0);
    cyc(); reset = 1'b0; t_data[0] = 32'hA5A5A5A5;
    for (int i = 0; i < 5; i++) begin
      expect_all($sformatf("rp_after%0d", i), 36'd0, 36'd0, 36'd0, 36'd0);
      cyc(); clr_in();
    end
    run1("postrst", 0, 4'd1, 2'd3, 32'h100, 32'h23, 2'd1, 32'h123);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc2_top.md
CALC2_TOP -- requirements
Module: calc2_top

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 c_clk  in  1  Single functional clock. All state changes on its rising edge.
REQ-003 reset  in  1  Asynchronous, active-high. It clears all state immediately.
REQ-004 reqN_cmd_in  in  4  Command for port N (N=1..4): 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right. All other values are invalid.
REQ-005 reqN_data_in  in  32  Operand 1 in the command cycle; operand 2 in the following cycle.
REQ-006 reqN_tag_in  in  2  Command tag. It is sampled in the command cycle.
REQ-007 out_dataN  out  32  Result for port N.
REQ-008 out_respN  out  2  Response for port N: 0 none, 1 success, 2 overflow/underflow/invalid command, 3 unused.
REQ-009 out_tagN  out  2  Tag of the command being answered on port N.
REQ-010 a_clk, b_clk, scan_in  in  1  Scan inputs. They are ignored.
REQ-010a scan_out  out  1  Tied to 0.

Function
REQ-011 A command is accepted on port N when reqN_cmd_in is nonzero in cycle T. Operand 2 is taken from reqN_data_in in cycle T+1; cmd is ignored in that cycle.
REQ-012 Each port has a 4-entry command queue of {cmd, tag, op1, op2}. Push occurs at the end of T+1.
REQ-013 The host guarantees that no port has more than 4 outstanding commands, and that outstanding tags within a port are unique. There is no backpressure.
REQ-014 Two execution units run concurrently:
- add/sub unit: cmd 1, cmd 2 and invalid commands
- shift unit: cmd 5 and cmd 6
REQ-015 Each unit dispatches at most one command per cycle. Selection is round-robin over ports 1-4, starting after the last granted port.
- Within a port, commands go to each unit in queue order.
- The oldest entry for a unit may be dispatched while older entries for the other unit remain queued.
REQ-016 Add: result = op1+op2 (unsigned). A carry-out gives resp 2 and data 0; otherwise resp 1 and the sum.
REQ-017 Subtract: result = op1-op2. If op2>op1 (unsigned), resp 2 and data 0; otherwise resp 1 and the difference.
REQ-018 Shift left/right: op1 shifted logically by op2[4:0] with zero fill. Resp is always 1.
REQ-019 Invalid command: resp 2, data 0. It still consumes two input cycles.
REQ-020 Each unit result is written into a per-port 4-entry response queue at the end of its dispatch cycle.
- If both units complete for the same port in the same cycle, the add/sub result is written first.
REQ-021 Each port presents at most one response per cycle, from the head of its response queue. The response is valid for exactly one cycle.
REQ-022 When no response is presented, out_resp=0, out_tag=0, out_data=0.
REQ-023 Minimum latency: command in cycle T, response visible in cycle T+3.
REQ-024 Responses from different units may return out of order. The tag identifies the command being answered.
REQ-025 The four ports operate independently. Simultaneous commands on all ports are legal.

Reset
REQ-026 While reset=1:
- all outputs are 0
- all command and response queues are empty
- any pending operand-2 capture is cancelled
- round-robin pointers point at port 1
REQ-027 Commands in flight when reset asserts are discarded and produce no response.
REQ-028 The first command is accepted in the first c_clk edge after reset deasserts.

Verification
REQ-029 Port 1 add, tag 2: op1=0x00000005, op2=0x00000007 -> T+3: out_resp1=1, out_tag1=2, out_data1=0x0000000C.
REQ-030 Port 2 add: op1=0xFFFFFFFF, op2=1 -> resp 2, data 0. Port 3 sub: op1=3, op2=5 -> resp 2, data 0. Port 3 sub: op1=5, op2=3 -> resp 1, data 2.
REQ-031 Port 4 shift left: op1=0x00000001, op2=0x00000024 -> resp 1, data 0x00000010 (shift amount 4). Shift right: op1=0x80000000, op2=31 -> data 1.
REQ-032 Port 1 cmd 3, tag 1 -> resp 2, tag 1, data 0. No other port produces a response.
REQ-033 All four ports issue add, tag 0, in the same cycle -> all four succeed with correct sums. Responses complete within 4 dispatch cycles in port order 1,2,3,4.
REQ-034 Port 1 issues add tag 0, then shift tag 1 with no gap, then reset pulses during the shift's operand-2 cycle -> no responses appear, and all outputs are 0 during and after reset.
